// File: rtl/minterm_lut_pkg.sv
// Shared types and constants for the runtime-reloadable minterm lookup table.
package minterm_lut_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } lut_state_t;

  localparam int          DEF_N_IN    = 4;
  // On-set {0,1,8,9,10,11,12,14,15}
  localparam logic [15:0] DEF_INIT_TT = 16'hDF03;

  // Number of minterms (truth-table bits) for an n-input function
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/minterm_eval_stage.sv
// One-deep registered valid/ready slot holding the evaluated function value.
module minterm_eval_stage
  import minterm_lut_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in_valid,
  input  logic f_p0,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic out_f
);

  logic vld_p1;
  logic f_p1;
  logic accept;

  // The slot can take a new request when it is empty or is being drained this cycle
  assign in_ready = en && (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;

  // ---- stage p0 -> p1: capture the looked-up bit, hold it while stalled ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      f_p1   <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      f_p1   <= f_p0;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_f     = f_p1;

endmodule

// File: rtl/minterm_lut_seq.sv
// N_IN-input Boolean function held as a truth table, with serial atomic reload,
// registered evaluation and an on-set counting sweep.
module minterm_lut_seq
  import minterm_lut_pkg::*;
#(
  parameter int                          N_IN    = DEF_N_IN,
  parameter logic [tt_width(N_IN)-1:0]   INIT_TT = DEF_INIT_TT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  input  logic            load_bit,
  output logic            load_ready,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vars,
  output logic            in_ready,
  output logic            out_valid,
  output logic            out_f,
  input  logic            out_ready,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic [N_IN:0]   sweep_count
);

  localparam int              TT_W     = tt_width(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TT_W - 1);

  lut_state_t       state_q, state_d;
  logic [TT_W-1:0]  table_q;
  logic [TT_W-1:0]  shadow_q;
  logic [TT_W-1:0]  shadow_wr;
  logic [N_IN-1:0]  load_idx_q;
  logic [N_IN-1:0]  sweep_idx_q;
  logic [N_IN:0]    acc_q;
  logic [N_IN:0]    acc_sum;
  logic [N_IN:0]    sweep_count_q;
  logic             sweep_done_q;
  logic             load_acc;
  logic             load_last;
  logic             sweep_last;
  logic             eval_en;
  logic             f_p0;

  assign load_acc   = load_valid && load_ready;
  assign load_last  = load_acc && (load_idx_q == LAST_IDX);
  assign sweep_last = (state_q == SWEEP) && (sweep_idx_q == LAST_IDX);

  // Shadow image including the beat arriving this cycle, so the commit sees it
  always_comb begin
    shadow_wr             = shadow_q;
    shadow_wr[load_idx_q] = load_bit;
  end

  assign acc_sum = acc_q + (N_IN+1)'(table_q[sweep_idx_q]);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: a sweep request beats a simultaneous load beat in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sweep_start)   state_d = SWEEP;
        else if (load_acc) state_d = LOAD;
      end
      LOAD: begin
        if (load_last) state_d = IDLE;
      end
      SWEEP: begin
        if (sweep_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: load handshake, busy flag and evaluation gating
  always_comb begin
    load_ready = 1'b0;
    sweep_busy = 1'b0;
    eval_en    = 1'b1;
    case (state_q)
      IDLE:  load_ready = !sweep_start;
      LOAD:  load_ready = 1'b1;
      SWEEP: begin
        sweep_busy = 1'b1;
        eval_en    = 1'b0;
      end
      default: ;
    endcase
  end

  // Serial load into the shadow; the live table only changes on the final beat
  always_ff @(posedge clk) begin
    if (rst) begin
      table_q    <= INIT_TT;
      shadow_q   <= '0;
      load_idx_q <= '0;
    end else if (load_acc) begin
      shadow_q <= shadow_wr;
      if (load_last) begin
        table_q    <= shadow_wr;
        load_idx_q <= '0;
      end else begin
        load_idx_q <= load_idx_q + 1'b1;
      end
    end
  end

  // On-set sweep: one minterm per cycle, result published on the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_idx_q   <= '0;
      acc_q         <= '0;
      sweep_count_q <= '0;
      sweep_done_q  <= 1'b0;
    end else begin
      sweep_done_q <= sweep_last;
      if (state_q == SWEEP) begin
        if (sweep_last) begin
          sweep_count_q <= acc_sum;
          acc_q         <= '0;
          sweep_idx_q   <= '0;
        end else begin
          acc_q       <= acc_sum;
          sweep_idx_q <= sweep_idx_q + 1'b1;
        end
      end
    end
  end

  assign sweep_done  = sweep_done_q;
  assign sweep_count = sweep_count_q;

  // ---- stage p0: combinational lookup in the committed table ----
  assign f_p0 = table_q[in_vars];

  minterm_eval_stage u_eval (
    .clk       (clk),
    .rst       (rst),
    .en        (eval_en),
    .in_valid  (in_valid),
    .f_p0      (f_p0),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_f     (out_f)
  );

endmodule

// File: tb/tb_minterm_lut_seq.sv
// Directed self-checking bench for minterm_lut_seq (default N_IN = 4).
module tb_minterm_lut_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_bit = 1'b0;
  logic       load_ready;
  logic       in_valid = 1'b0;
  logic [3:0] in_vars = 4'd0;
  logic       in_ready;
  logic       out_valid;
  logic       out_f;
  logic       out_ready = 1'b1;
  logic       sweep_start = 1'b0;
  logic       sweep_busy;
  logic       sweep_done;
  logic [4:0] sweep_count;

  int n_checks = 0;
  int n_errors = 0;

  minterm_lut_seq dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_bit    (load_bit),
    .load_ready  (load_ready),
    .in_valid    (in_valid),
    .in_vars     (in_vars),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_f       (out_f),
    .out_ready   (out_ready),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .sweep_count (sweep_count)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic eval_chk(input logic [3:0] v, input logic exp, input string tag);
    in_valid = 1'b1;
    in_vars  = v;
    step();
    in_valid = 1'b0;
    chk_val({tag, "_vld"}, out_valid, 1);
    chk_val({tag, "_f"}, out_f, exp);
  endtask

  task automatic load_tt(input logic [15:0] v, input int nb);
    for (int b = 0; b < nb; b++) begin
      load_valid = 1'b1;
      load_bit   = v[b];
      step();
    end
    load_valid = 1'b0;
    load_bit   = 1'b0;
  endtask

  task automatic run_sweep(input logic [4:0] exp_cnt, input bit conflict, input string tag);
    int busy_n;
    bit ir_hi;
    sweep_start = 1'b1;
    load_valid  = conflict;
    load_bit    = 1'b1;
    #1;
    if (conflict) chk_val({tag, "_ldrdy"}, load_ready, 0);
    step();
    sweep_start = 1'b0;
    load_valid  = 1'b0;
    load_bit    = 1'b0;
    busy_n = 0;
    ir_hi  = 1'b0;
    for (int c = 0; c < 40 && sweep_busy; c++) begin
      busy_n++;
      if (in_ready) ir_hi = 1'b1;
      step();
    end
    chk_val({tag, "_busy_cycles"}, busy_n, 16);
    chk_val({tag, "_inrdy_low"}, ir_hi, 0);
    chk_val({tag, "_done"}, sweep_done, 1);
    chk_val({tag, "_count"}, sweep_count, exp_cnt);
    step();
    chk_val({tag, "_done_pulse"}, sweep_done, 0);
    chk_val({tag, "_count_hold"}, sweep_count, exp_cnt);
  endtask

  initial begin
    logic [15:0] tt0;
    tt0 = 16'hDF03;

    // Reset state
    repeat (2) step();
    rst = 1'b0;
    step();
    chk_val("rst_out_valid", out_valid, 0);
    chk_val("rst_out_f", out_f, 0);
    chk_val("rst_sweep_busy", sweep_busy, 0);
    chk_val("rst_sweep_done", sweep_done, 0);
    chk_val("rst_sweep_count", sweep_count, 0);
    chk_val("rst_load_ready", load_ready, 1);
    chk_val("rst_in_ready", in_ready, 1);

    // 1: back-to-back evaluation of every minterm of the reset table
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_vars = 4'(i);
      step();
      chk_val($sformatf("t1_vld_%0d", i), out_valid, 1);
      chk_val($sformatf("t1_f_%0d", i), out_f, tt0[i]);
      chk_val($sformatf("t1_inrdy_%0d", i), in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk_val("t1_drain", out_valid, 0);

    // 2: sweep of the reset table
    run_sweep(5'd9, 1'b0, "t2");

    // 6: sweep and load beat in the same IDLE cycle; the beat must be dropped
    run_sweep(5'd9, 1'b1, "t6");

    // 5: stalled output slot
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vars   = 4'd0;
    step();
    chk_val("t5_vld0", out_valid, 1);
    chk_val("t5_f0", out_f, 1);
    in_vars = 4'd2;
    for (int k = 0; k < 2; k++) begin
      chk_val($sformatf("t5_inrdy_%0d", k), in_ready, 0);
      step();
      chk_val($sformatf("t5_hold_vld_%0d", k), out_valid, 1);
      chk_val($sformatf("t5_hold_f_%0d", k), out_f, 1);
    end
    out_ready = 1'b1;
    step();
    chk_val("t5_f2", out_f, 0);
    in_vars = 4'd8;
    step();
    chk_val("t5_f8", out_f, 1);
    in_vars = 4'd5;
    step();
    chk_val("t5_f5", out_f, 0);
    chk_val("t5_vld5", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk_val("t5_drain", out_valid, 0);

    // 3: load 16'h0001, with an evaluation of minterm 1 in the commit cycle
    load_tt(16'h0001, 15);
    load_valid = 1'b1;
    load_bit   = 1'b0;
    in_valid   = 1'b1;
    in_vars    = 4'd1;
    step();
    load_valid = 1'b0;
    in_valid   = 1'b0;
    chk_val("t3_commit_old_f", out_f, 1);
    eval_chk(4'd1, 1'b0, "t3_new1");
    eval_chk(4'd0, 1'b1, "t3_eval0");
    eval_chk(4'd5, 1'b0, "t3_eval5");
    step();
    run_sweep(5'd1, 1'b0, "t3");

    // 4: partial load then reset with a pending result
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vars   = 4'd0;
    step();
    in_valid = 1'b0;
    chk_val("t4_pending", out_valid, 1);
    load_tt(16'h0000, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    chk_val("t4_rst_vld", out_valid, 0);
    chk_val("t4_rst_f", out_f, 0);
    chk_val("t4_rst_count", sweep_count, 0);
    chk_val("t4_rst_ldrdy", load_ready, 1);
    eval_chk(4'd15, 1'b1, "t4_eval15");
    eval_chk(4'd1, 1'b1, "t4_eval1");
    eval_chk(4'd2, 1'b0, "t4_eval2");
    load_tt(16'hFFFF, 16);
    eval_chk(4'd2, 1'b1, "t4_ones2");
    step();
    run_sweep(5'd16, 1'b0, "t4");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time guard so the run always ends on its own
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
